oled_pixel_streamer: RTL

Initiator side of the pixel interface used by every Game_Screen block. It scans the 96x64 OLED pixel by pixel, drives x/y to a screen generator and samples the 16-bit RGB565 oled_data returned combinationally. Each sampled word is serialized MSB-first over the panel's 4-wire SPI (sclk/sdin/cs_n/d_cn). Panel power-up and command initialisation belong to a separate controller; this block only streams pixel data once enabled.

---
 rtl/oled_pkg.sv | 24 ++
 rtl/spi_word_shifter.sv | 58 +++++
 rtl/oled_pixel_streamer.sv | 118 +++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared OLED definitions: panel geometry, RGB565 palette and the streamer state encoding.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

  localparam logic [15:0] COLOR_BLACK   = 16'h0000;
  localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
  localparam logic [15:0] COLOR_RED     = 16'hF800;
  localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE    = 16'h001F;
  localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
  localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } streamer_state_t;

endpackage

// File: rtl/spi_word_shifter.sv
// Serialises one 16-bit word MSB first: each bit is held 2*clk_div clks, sclk low then high.
module spi_word_shifter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [15:0] i_data,
  input  logic [7:0]  i_clk_div,
  output logic        o_sclk,
  output logic        o_sdin,
  output logic        o_done
);

  logic [14:0] r_data;
  logic [3:0]  r_bit;
  logic [8:0]  r_cnt;
  logic        r_active;
  logic [8:0]  w_half_end;
  logic [8:0]  w_bit_end;

  assign w_half_end = {1'b0, i_clk_div} - 9'd1;
  assign w_bit_end  = {i_clk_div, 1'b0} - 9'd1;
  assign o_done     = r_active && (r_bit == 4'd0) && (r_cnt == w_bit_end);

  // Bit 15 goes straight to sdin on load; r_data holds the 15 bits still to send.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data   <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      o_sclk   <= 1'b1;
      o_sdin   <= 1'b0;
    end else if (i_load) begin
      r_data   <= i_data[14:0];
      r_bit    <= 4'd15;
      r_cnt    <= '0;
      r_active <= 1'b1;
      o_sclk   <= 1'b0;
      o_sdin   <= i_data[15];
    end else if (r_active) begin
      if (r_cnt == w_bit_end) begin
        r_cnt <= '0;
        if (r_bit == 4'd0) begin
          r_active <= 1'b0;
        end else begin
          r_bit  <= r_bit - 4'd1;
          r_data <= {r_data[13:0], 1'b0};
          o_sdin <= r_data[14];
          o_sclk <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + 9'd1;
        if (r_cnt == w_half_end) o_sclk <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_pixel_streamer.sv
// Scans the panel pixel by pixel, samples the screen generator's colour and streams it over SPI.
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH   = OLED_WIDTH,
  parameter int HEIGHT  = OLED_HEIGHT,
  parameter int CLK_DIV = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_enable,
  input  logic [15:0]     i_oled_data,
  output logic [6:0]      o_x,
  output logic [5:0]      o_y,
  output logic [12:0]     o_pixel_index,
  output logic            o_frame_begin,
  output logic            o_busy,
  output logic            o_sclk,
  output logic            o_sdin,
  output logic            o_cs_n,
  output logic            o_d_cn,
  output streamer_state_t o_state
);

  streamer_state_t r_state;
  logic [6:0]      r_x;
  logic [5:0]      r_y;
  logic [12:0]     r_idx;
  logic            r_frame_begin;
  logic            r_busy;
  logic            r_cs_n;
  logic            w_load;
  logic            w_done;
  logic            w_last_col;
  logic            w_last_row;
  logic [6:0]      w_next_x;
  logic [5:0]      w_next_y;
  logic [12:0]     w_next_idx;

  assign w_load     = (r_state == FETCH);
  assign w_last_col = (r_x == 7'(WIDTH - 1));
  assign w_last_row = (r_y == 6'(HEIGHT - 1));

  always_comb begin
    w_next_x   = w_last_col ? 7'd0 : r_x + 7'd1;
    w_next_y   = r_y;
    if (w_last_col) w_next_y = w_last_row ? 6'd0 : r_y + 6'd1;
    w_next_idx = (w_last_col && w_last_row) ? 13'd0 : r_idx + 13'd1;
  end

  spi_word_shifter u_shifter (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_data    (i_oled_data),
    .i_clk_div (8'(CLK_DIV)),
    .o_sclk    (o_sclk),
    .o_sdin    (o_sdin),
    .o_done    (w_done)
  );

  // frame_begin is decided on the edge entering FETCH so it lines up with that cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_idx         <= '0;
      r_frame_begin <= 1'b0;
      r_busy        <= 1'b0;
      r_cs_n        <= 1'b1;
    end else begin
      r_frame_begin <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state       <= FETCH;
            r_busy        <= 1'b1;
            r_frame_begin <= (r_x == 7'd0) && (r_y == 6'd0);
          end
        end
        FETCH: begin
          r_state <= SHIFT;
          r_cs_n  <= 1'b0;
        end
        SHIFT: begin
          if (w_done) begin
            r_state <= GAP;
            r_cs_n  <= 1'b1;
          end
        end
        GAP: begin
          r_x   <= w_next_x;
          r_y   <= w_next_y;
          r_idx <= w_next_idx;
          if (i_enable) begin
            r_state       <= FETCH;
            r_frame_begin <= w_last_col && w_last_row;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_pixel_index = r_idx;
  assign o_frame_begin = r_frame_begin;
  assign o_busy        = r_busy;
  assign o_cs_n        = r_cs_n;
  assign o_d_cn        = 1'b1;
  assign o_state       = r_state;

endmodule
